i2c_master_arbiter: RTL and testbench

Shares one `i2c_master` instance between `NUM_REQ` independent requesters (register-access engines, sensor pollers, host bridge) using round-robin arbitration. Each requester presents a complete register transaction. The arbiter muxes it onto the master, pulses `we`/`re`, waits for `done`, and returns `datao`/`status` to the winning requester. It sits between the requester blocks and the `i2c_master` instance, with the master's ports connected 1:1 to the `m_*` ports.

---
 rtl/i2c_arb_pkg.sv | 13 +
 rtl/i2c_master_arbiter_if.sv | 18 +
 rtl/i2c_rr_pick.sv | 23 ++
 rtl/i2c_master_arbiter.sv | 129 ++++++++++++
 tb/tb_i2c_master_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and constants for the i2c_master round-robin arbiter.
// DRAIN exists only when I2C_ARB_TIMEOUT_EN is defined.
package i2c_arb_pkg;
`ifdef I2C_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESP, DRAIN} arb_state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESP} arb_state_t;
`endif
    localparam logic [6:0] STATUS_TIMEOUT = 7'h7F;
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: transaction/result bundle between the arbiter (master) and the shared i2c_master (slave).
interface i2c_master_arbiter_if #(
    parameter int NUM_ADDR_BYTES = 2,
    parameter int NUM_DATA_BYTES = 4
);
    logic [6:0]                  chip_addr;
    logic [NUM_ADDR_BYTES*8-1:0] reg_addr;
    logic [NUM_DATA_BYTES*8-1:0] datai;
    logic                        write_mode;
    logic                        we;
    logic                        re;
    logic                        done;
    logic                        busy;
    logic [6:0]                  status;
    logic [NUM_DATA_BYTES*8-1:0] datao;
    modport master (output chip_addr, reg_addr, datai, write_mode, we, re, input done, busy, status, datao);
    modport slave  (input chip_addr, reg_addr, datai, write_mode, we, re, output done, busy, status, datao);
endinterface

// File: rtl/i2c_rr_pick.sv
// i2c_rr_pick: combinational round-robin picker, first request at or after ptr, wrapping modulo N.
module i2c_rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int W = ptr_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         valid
);
    always_comb begin
        idx = '0;
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = W'((int'(ptr) + k) % N);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: shares one i2c_master among NUM_REQ requesters with round-robin grants.
// Define I2C_ARB_TIMEOUT_EN to bound WAIT_DONE by TIMEOUT_CYCLES and add the DRAIN recovery state.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_ADDR_BYTES = 2,
    parameter int NUM_DATA_BYTES = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int W = ptr_width(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_REQ-1:0]                  req_we,
    input  logic [NUM_REQ-1:0]                  req_re,
    input  logic [NUM_REQ-1:0]                  req_write_mode,
    input  logic [NUM_REQ*7-1:0]                req_chip_addr,
    input  logic [NUM_REQ*NUM_ADDR_BYTES*8-1:0] req_reg_addr,
    input  logic [NUM_REQ*NUM_DATA_BYTES*8-1:0] req_datai,
    output logic [NUM_REQ-1:0]                  rsp_done,
    output logic [NUM_DATA_BYTES*8-1:0]         rsp_datao,
    output logic [6:0]                          rsp_status,
    output logic                                rsp_timeout,
    output logic [W-1:0]                        grant_id,
    output logic                                arb_busy,
    i2c_master_arbiter_if.master                m
);
    localparam int AW = NUM_ADDR_BYTES * 8;
    localparam int DW = NUM_DATA_BYTES * 8;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("i2c_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
    end

    arb_state_t    state, state_n;
    logic [W-1:0]  ptr, pick_idx;
    logic          pick_valid, timeout_hit;
    logic [6:0]    chip_a [NUM_REQ];
    logic [AW-1:0] reg_a  [NUM_REQ];
    logic [DW-1:0] data_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign chip_a[i] = req_chip_addr[7*i +: 7];
        assign reg_a[i]  = req_reg_addr[AW*i +: AW];
        assign data_a[i] = req_datai[DW*i +: DW];
    end

    i2c_rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_we | req_re),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] cnt;
    always_ff @(posedge clk) cnt <= (!reset_n || state != WAIT_DONE) ? '0 : cnt + 32'd1;
    assign timeout_hit = (state == WAIT_DONE) && (cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign arb_busy = (state != IDLE);

    always_ff @(posedge clk) state <= reset_n ? state_n : IDLE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = (pick_valid && !m.busy) ? ISSUE : IDLE;
            ISSUE:     state_n = WAIT_DONE;
            WAIT_DONE: state_n = (m.done || timeout_hit) ? RESP : WAIT_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
            RESP:      state_n = rsp_timeout ? DRAIN : IDLE;
            DRAIN:     state_n = (m.busy || m.done) ? DRAIN : IDLE;
`else
            RESP:      state_n = IDLE;
`endif
            default:   state_n = IDLE;
        endcase
    end

    // Fields are latched at grant so they stay stable even if the requester drops early.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr          <= '0;
            grant_id     <= '0;
            rsp_done     <= '0;
            rsp_datao    <= '0;
            rsp_status   <= '0;
            m.chip_addr  <= '0;
            m.reg_addr   <= '0;
            m.datai      <= '0;
            m.write_mode <= 1'b0;
            m.we         <= 1'b0;
            m.re         <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
`endif
        end else begin
            m.we     <= 1'b0;
            m.re     <= 1'b0;
            rsp_done <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            if (state == IDLE && state_n == ISSUE) begin
                grant_id     <= pick_idx;
                m.chip_addr  <= chip_a[pick_idx];
                m.reg_addr   <= reg_a[pick_idx];
                m.datai      <= data_a[pick_idx];
                m.write_mode <= req_write_mode[pick_idx];
                m.we         <= req_we[pick_idx];
                m.re         <= req_re[pick_idx] & ~req_we[pick_idx];
            end
            if (state == WAIT_DONE && state_n == RESP) begin
                rsp_done[grant_id] <= 1'b1;
                rsp_datao          <= m.done ? m.datao : '0;
                rsp_status         <= m.done ? m.status : STATUS_TIMEOUT;
`ifdef I2C_ARB_TIMEOUT_EN
                rsp_timeout        <= ~m.done;
`endif
            end
            if (state == RESP)
                ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: directed and randomized checks of the arbiter against a round-robin reference model.
module tb_i2c_master_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_we, req_re, req_write_mode;
    logic [6:0]      chip [N];
    logic [15:0]     rega [N];
    logic [31:0]     dati [N];
    logic [N*7-1:0]  req_chip_addr;
    logic [N*16-1:0] req_reg_addr;
    logic [N*32-1:0] req_datai;
    logic [N-1:0]    rsp_done;
    logic [31:0]     rsp_datao;
    logic [6:0]      rsp_status;
    logic            rsp_timeout;
    logic [1:0]      grant_id;
    logic            arb_busy;

    i2c_master_arbiter_if #(.NUM_ADDR_BYTES(2), .NUM_DATA_BYTES(4)) m ();

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_chip_addr[7*i +: 7]  = chip[i];
        assign req_reg_addr[16*i +: 16] = rega[i];
        assign req_datai[32*i +: 32]    = dati[i];
    end

    i2c_master_arbiter #(
        .NUM_REQ(N), .NUM_ADDR_BYTES(2), .NUM_DATA_BYTES(4), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_we(req_we), .req_re(req_re), .req_write_mode(req_write_mode),
        .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_datai(req_datai),
        .rsp_done(rsp_done), .rsp_datao(rsp_datao), .rsp_status(rsp_status),
        .rsp_timeout(rsp_timeout), .grant_id(grant_id), .arb_busy(arb_busy),
        .m(m)
    );

    int tests = 0, fails = 0, ref_ptr = 0;
    int cyc = 0, done_cyc = 0;
    int we_cnt = 0, re_cnt = 0, rsp_cnt = 0;
    bit model_en = 1'b1;
    int lat = 3;
    logic [31:0] mdat = '0;
    logic [6:0]  msts = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m.we) we_cnt++;
        if (m.re) re_cnt++;
        if (rsp_done != '0) rsp_cnt++;
    end

    // Behavioural i2c_master: one start pulse, lat cycles later a one-cycle done with mdat/msts.
    initial begin
        m.done = 1'b0;
        m.status = '0;
        m.datao = '0;
        forever begin
            @(posedge clk);
            #1;
            if (model_en && (m.we || m.re)) begin
                repeat (lat) @(posedge clk);
                #1;
                m.done = 1'b1;
                m.datao = mdat;
                m.status = msts;
                done_cyc = cyc;
                @(posedge clk);
                #1;
                m.done = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d want finish", cyc);
        $fatal(1);
    end

    function automatic int rr_winner(input int p, input logic [N-1:0] pend);
        for (int k = 0; k < N; k++)
            if (pend[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = m.we || m.re;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (rsp_done != '0);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({rsp_done, rsp_timeout, grant_id, arb_busy, m.we, m.re} !== 10'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 0", {rsp_done, rsp_timeout, grant_id, arb_busy, m.we, m.re});
        end
        tests++;
        if ({rsp_datao, rsp_status, m.chip_addr, m.reg_addr, m.datai, m.write_mode} !== 95'b0) begin
            fails++;
            $display("FAIL reset_data got %h want 0", {rsp_datao, rsp_status, m.chip_addr, m.reg_addr, m.datai, m.write_mode});
        end
    endtask

    task automatic test_fairness;
        bit ok;
        int r0, q0;
        logic [N-1:0] exp;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chip[i] = 7'(8'h10 + i);
            rega[i] = 16'(i * 16'h0101);
        end
        req_re = '1;
        r0 = rsp_cnt;
        q0 = re_cnt;
        @(negedge clk);
        reset_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            mdat = $urandom;
            msts = '0;
            lat = $urandom_range(1, 4);
            wait_rsp(ok);
            exp = N'(1) << (t % N);
            tests++;
            if (!ok || rsp_done !== exp) begin
                fails++;
                $display("FAIL rr_order txn %0d got %b want %b", t, rsp_done, exp);
            end
            tests++;
            if (rsp_datao !== mdat) begin
                fails++;
                $display("FAIL rr_datao txn %0d got %h want %h", t, rsp_datao, mdat);
            end
            if (t == 4) begin
                @(negedge clk);
                req_re = '0;
            end
        end
        repeat (4) @(negedge clk);
        tests++;
        if (rsp_cnt - r0 !== 5 || re_cnt - q0 !== 5) begin
            fails++;
            $display("FAIL rr_counts got rsp %0d re %0d want 5 5", rsp_cnt - r0, re_cnt - q0);
        end
        ref_ptr = 1;
    endtask

    task automatic test_single_read;
        bit ok;
        int q0, w0;
        @(negedge clk);
        chip[2] = 7'h21;
        rega[2] = 16'h0010;
        req_re[2] = 1'b1;
        lat = 40;
        mdat = 32'hDEADBEEF;
        msts = 7'h00;
        q0 = re_cnt;
        w0 = we_cnt;
        wait_issue(ok);
        tests++;
        if (!ok || m.re !== 1'b1 || m.we !== 1'b0 || grant_id !== 2'd2) begin
            fails++;
            $display("FAIL read_issue got re %b we %b grant %0d want 1 0 2", m.re, m.we, grant_id);
        end
        tests++;
        if (m.chip_addr !== 7'h21 || m.reg_addr !== 16'h0010) begin
            fails++;
            $display("FAIL read_fields got %h/%h want 21/0010", m.chip_addr, m.reg_addr);
        end
        wait_rsp(ok);
        tests++;
        if (!ok || rsp_done !== 4'b0100 || cyc !== done_cyc + 1) begin
            fails++;
            $display("FAIL read_done got %b at cycle %0d want 0100 at %0d", rsp_done, cyc, done_cyc + 1);
        end
        tests++;
        if (rsp_datao !== 32'hDEADBEEF || rsp_status !== 7'h00) begin
            fails++;
            $display("FAIL read_data got %h/%h want deadbeef/00", rsp_datao, rsp_status);
        end
        @(negedge clk);
        req_re[2] = 1'b0;
        tests++;
        if (re_cnt - q0 !== 1 || we_cnt - w0 !== 0) begin
            fails++;
            $display("FAIL read_pulses got re %0d we %0d want 1 0", re_cnt - q0, we_cnt - w0);
        end
        ref_ptr = 3;
    endtask

    task automatic test_write_priority;
        bit ok;
        @(negedge clk);
        dati[1] = $urandom;
        req_write_mode[1] = 1'b1;
        req_we[1] = 1'b1;
        req_re[1] = 1'b1;
        lat = 3;
        mdat = $urandom;
        wait_issue(ok);
        tests++;
        if (!ok || m.we !== 1'b1 || m.re !== 1'b0 || grant_id !== 2'd1) begin
            fails++;
            $display("FAIL wr_prio got we %b re %b grant %0d want 1 0 1", m.we, m.re, grant_id);
        end
        tests++;
        if (m.datai !== dati[1] || m.write_mode !== 1'b1) begin
            fails++;
            $display("FAIL wr_data got %h/%b want %h/1", m.datai, m.write_mode, dati[1]);
        end
        wait_rsp(ok);
        tests++;
        if (!ok || rsp_done !== 4'b0010) begin
            fails++;
            $display("FAIL wr_done got %b want 0010", rsp_done);
        end
        @(negedge clk);
        req_we[1] = 1'b0;
        req_re[1] = 1'b0;
        req_write_mode[1] = 1'b0;
        ref_ptr = 2;
    endtask

    task automatic test_busy_holdoff;
        bit ok;
        int base, fall_cyc, d;
        @(negedge clk);
        m.busy = 1'b1;
        req_re[3] = 1'b1;
        base = we_cnt + re_cnt;
        repeat (10) @(negedge clk);
        tests++;
        if (we_cnt + re_cnt !== base || arb_busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_hold got %0d pulses busy %b want 0 0", we_cnt + re_cnt - base, arb_busy);
        end
        m.busy = 1'b0;
        fall_cyc = cyc;
        wait_issue(ok);
        d = cyc - fall_cyc;
        tests++;
        if (!ok || d < 1 || d > 2 || grant_id !== 2'd3) begin
            fails++;
            $display("FAIL busy_release got delay %0d grant %0d want 1..2 3", d, grant_id);
        end
        wait_rsp(ok);
        @(negedge clk);
        req_re[3] = 1'b0;
        ref_ptr = 0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int r0;
        @(negedge clk);
        req_re[2] = 1'b1;
        lat = 20;
        wait_issue(ok);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        req_re[2] = 1'b0;
        r0 = rsp_cnt;
        @(posedge clk);
        #1;
        tests++;
        if ({rsp_done, grant_id, arb_busy, m.we, m.re, m.chip_addr, m.reg_addr, m.datai} !== '0) begin
            fails++;
            $display("FAIL midreset_out got %h want 0", {rsp_done, grant_id, arb_busy, m.we, m.re, m.chip_addr, m.reg_addr, m.datai});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        tests++;
        if (rsp_cnt !== r0) begin
            fails++;
            $display("FAIL midreset_nodone got %0d pulses want 0", rsp_cnt - r0);
        end
        lat = 2;
        req_re[1] = 1'b1;
        req_re[3] = 1'b1;
        wait_issue(ok);
        tests++;
        if (!ok || grant_id !== 2'd1) begin
            fails++;
            $display("FAIL midreset_ptr got grant %0d want 1", grant_id);
        end
        wait_rsp(ok);
        @(negedge clk);
        req_re[1] = 1'b0;
        wait_issue(ok);
        tests++;
        if (!ok || grant_id !== 2'd3) begin
            fails++;
            $display("FAIL midreset_next got grant %0d want 3", grant_id);
        end
        wait_rsp(ok);
        @(negedge clk);
        req_re[3] = 1'b0;
        ref_ptr = 0;
    endtask

    task automatic test_random;
        bit ok;
        int g;
        logic exp_we, exp_re;
        logic [N-1:0] exp;
        @(negedge clk);
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_we[i] || req_re[i]) && ($urandom_range(0, 1) == 1 || (req_we | req_re) == '0)) begin
                    chip[i] = 7'($urandom);
                    rega[i] = 16'($urandom);
                    dati[i] = $urandom;
                    req_write_mode[i] = 1'($urandom);
                    case ($urandom_range(0, 2))
                        0: begin req_re[i] = 1'b1; req_we[i] = 1'b0; end
                        1: begin req_re[i] = 1'b0; req_we[i] = 1'b1; end
                        default: begin req_re[i] = 1'b1; req_we[i] = 1'b1; end
                    endcase
                end
            end
            g = rr_winner(ref_ptr, req_we | req_re);
            exp_we = req_we[g];
            exp_re = req_re[g] && !req_we[g];
            lat = $urandom_range(1, 6);
            mdat = $urandom;
            msts = 7'($urandom);
            wait_issue(ok);
            tests++;
            if (!ok || int'(grant_id) !== g || m.we !== exp_we || m.re !== exp_re) begin
                fails++;
                $display("FAIL rand_grant txn %0d got %0d we %b re %b want %0d %b %b", t, grant_id, m.we, m.re, g, exp_we, exp_re);
            end
            tests++;
            if (m.chip_addr !== chip[g] || m.reg_addr !== rega[g] || m.datai !== dati[g] || m.write_mode !== req_write_mode[g]) begin
                fails++;
                $display("FAIL rand_fields txn %0d got %h/%h/%h/%b want %h/%h/%h/%b", t, m.chip_addr, m.reg_addr, m.datai, m.write_mode, chip[g], rega[g], dati[g], req_write_mode[g]);
            end
            wait_rsp(ok);
            exp = N'(1) << g;
            tests++;
            if (!ok || rsp_done !== exp || rsp_datao !== mdat || rsp_status !== msts || rsp_timeout !== 1'b0) begin
                fails++;
                $display("FAIL rand_rsp txn %0d got %b/%h/%h want %b/%h/%h", t, rsp_done, rsp_datao, rsp_status, exp, mdat, msts);
            end
            @(negedge clk);
            req_we[g] = 1'b0;
            req_re[g] = 1'b0;
            ref_ptr = (g + 1) % N;
        end
        while ((req_we | req_re) != '0) begin
            g = rr_winner(ref_ptr, req_we | req_re);
            wait_rsp(ok);
            @(negedge clk);
            req_we[g] = 1'b0;
            req_re[g] = 1'b0;
            ref_ptr = (g + 1) % N;
        end
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        int ic, base;
        model_en = 1'b0;
        @(negedge clk);
        req_re[0] = 1'b1;
        wait_issue(ok);
        ic = cyc;
        wait_rsp(ok);
        tests++;
        if (!ok || cyc - ic !== 101 || rsp_done !== 4'b0001) begin
            fails++;
            $display("FAIL to_delay got %0d cycles done %b want 101 0001", cyc - ic, rsp_done);
        end
        tests++;
        if (rsp_timeout !== 1'b1 || rsp_status !== 7'h7F || rsp_datao !== 32'h0) begin
            fails++;
            $display("FAIL to_rsp got %b/%h/%h want 1/7f/0", rsp_timeout, rsp_status, rsp_datao);
        end
        @(negedge clk);
        req_re[0] = 1'b0;
        req_re[2] = 1'b1;
        m.busy = 1'b1;
        base = we_cnt + re_cnt;
        repeat (10) @(negedge clk);
        tests++;
        if (we_cnt + re_cnt !== base) begin
            fails++;
            $display("FAIL to_drain got %0d pulses want 0", we_cnt + re_cnt - base);
        end
        model_en = 1'b1;
        lat = 2;
        m.busy = 1'b0;
        wait_issue(ok);
        tests++;
        if (!ok || grant_id !== 2'd2) begin
            fails++;
            $display("FAIL to_resume got grant %0d want 2", grant_id);
        end
        wait_rsp(ok);
        @(negedge clk);
        req_re[2] = 1'b0;
    endtask
`endif

    initial begin
        req_we = '0;
        req_re = '0;
        req_write_mode = '0;
        m.busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            chip[i] = '0;
            rega[i] = '0;
            dati[i] = '0;
        end
        test_reset;
        test_fairness;
        test_single_read;
        test_write_priority;
        test_busy_holdoff;
        test_reset_mid;
        test_random;
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
